// File: rtl/interconn_xbar_fifo_pkg.sv
// Shared widths and helpers for the buffered crossbar.
// Defaults match an 8-core MVU cluster with 128-bit words.
package ic_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   localparam int N_DEF     = 8;
   localparam int W_DEF     = 128;
   localparam int DEPTH_DEF = 4;
   localparam int A         = clog2(N_DEF);
   localparam int C         = clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/interconn_fifo.sv
// Per-sender word FIFO: power-of-two ring with a separate count so full/empty differ.
// Pushes to a full FIFO are dropped and flagged in a sticky overflow bit.
module interconn_fifo
   import ic_pkg::*;
#(
   parameter int W     = 128,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic                           push,
   input  logic [W-1:0]                   din,
   input  logic                           pop,
   output logic [W-1:0]                   head,
   output logic [clog2(DEPTH+1)-1:0]      count,
   output logic                           full,
   output logic                           empty,
   output logic                           ovf
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          push_ok, pop_ok;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_ok = push & ~full & ~clr;
   assign pop_ok  = pop & ~empty & ~clr;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (push_ok) wr_d = wr_q + 1'b1;
         if (pop_ok)  rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
         // A concurrent pop does not make room for this cycle's push.
         if (push && full) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/interconn_xbar_fifo.sv
// Buffered N-port crossbar: one FIFO per sender, lockstep multicast to all
// receivers attached to a source; the source pops only when every reader is ready.
module interconn_xbar_fifo
   import ic_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr,
   input  logic [N-1:0]                       send_en,
   input  logic [N*W-1:0]                     send_word,
   output logic [N-1:0]                       send_rdy,
   input  logic [N-1:0]                       recv_act,
   input  logic [N*clog2(N)-1:0]              recv_from,
   input  logic [N-1:0]                       recv_rdy,
   output logic [N-1:0]                       recv_en,
   output logic [N*W-1:0]                     recv_word,
   output logic [N*clog2(DEPTH+1)-1:0]        occ,
   output logic [N-1:0]                       err_ovf
);

   localparam int AW = clog2(N);
   localparam int CW = clog2(DEPTH + 1);

   logic [W-1:0]         head  [N];
   logic [CW-1:0]        count [N];
   logic [N-1:0]         full, empty, ovf, fire;
   logic [N-1:0][N-1:0]  member;   // member[s][j]: receiver j reads source s

   for (genvar s = 0; s < N; s++) begin : g_fifo
      interconn_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .push  (send_en[s]),
         .din   (send_word[s*W +: W]),
         .pop   (fire[s]),
         .head  (head[s]),
         .count (count[s]),
         .full  (full[s]),
         .empty (empty[s]),
         .ovf   (ovf[s])
      );
      assign occ[s*CW +: CW] = count[s];
   end

   assign send_rdy = ~full;
   assign err_ovf  = ovf;

   always_comb begin
      member = '0;
      fire   = '0;
      for (int s = 0; s < N; s++) begin
         for (int j = 0; j < N; j++) begin
            member[s][j] = recv_act[j] && (int'(recv_from[j*AW +: AW]) == s);
         end
         fire[s] = ~empty[s] & (|member[s]) & (&(~member[s] | recv_rdy));
      end
   end

   // A receiver's valid ignores its own ready so ready may depend on valid.
   always_comb begin
      logic [AW-1:0] src;
      logic          others_rdy;
      recv_en   = '0;
      recv_word = '0;
      for (int j = 0; j < N; j++) begin
         src        = recv_from[j*AW +: AW];
         others_rdy = 1'b1;
         if (recv_act[j] && (int'(src) < N)) begin
            for (int k = 0; k < N; k++) begin
               if (k != j && member[src][k] && !recv_rdy[k]) others_rdy = 1'b0;
            end
            recv_en[j] = ~empty[src] & others_rdy & ~clr;
            if (recv_en[j]) recv_word[j*W +: W] = head[src];
         end
      end
   end

endmodule

// File: tb/tb_interconn_xbar_fifo.sv
// Directed bench for interconn_xbar_fifo: vector table plus hand-written
// sequences for FIFO wrap, clear and asynchronous reset.
module tb_interconn_xbar_fifo;
   import ic_pkg::*;

   localparam int N     = 8;
   localparam int W     = 128;
   localparam int DEPTH = 4;
   localparam int AB    = clog2(N);
   localparam int CB    = clog2(DEPTH + 1);

   logic               clk = 1'b0;
   logic               rst_n;
   logic               clr;
   logic [N-1:0]       send_en;
   logic [N*W-1:0]     send_word;
   logic [N-1:0]       send_rdy;
   logic [N-1:0]       recv_act;
   logic [N*AB-1:0]    recv_from;
   logic [N-1:0]       recv_rdy;
   logic [N-1:0]       recv_en;
   logic [N*W-1:0]     recv_word;
   logic [N*CB-1:0]    occ;
   logic [N-1:0]       err_ovf;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0]    send_en;
      logic [W-1:0]    data;
      logic [N-1:0]    act;
      logic [N*AB-1:0] from;
      logic [N-1:0]    rdy;
      logic [N-1:0]    exp_en;
      int              rx;
      logic [W-1:0]    exp_word;
      logic [N*CB-1:0] exp_occ;
      logic [N-1:0]    exp_srdy;
      logic [N-1:0]    exp_ovf;
   } vec_t;

   vec_t tbl[$];

   interconn_xbar_fifo #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .send_en   (send_en),
      .send_word (send_word),
      .send_rdy  (send_rdy),
      .recv_act  (recv_act),
      .recv_from (recv_from),
      .recv_rdy  (recv_rdy),
      .recv_en   (recv_en),
      .recv_word (recv_word),
      .occ       (occ),
      .err_ovf   (err_ovf)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [N*AB-1:0] fr(input int j, input int s);
      logic [N*AB-1:0] r;
      r = '0;
      r[j*AB +: AB] = AB'(s);
      return r;
   endfunction

   function automatic logic [N*CB-1:0] oc(input int i, input int n);
      logic [N*CB-1:0] r;
      r = '0;
      r[i*CB +: CB] = CB'(n);
      return r;
   endfunction

   function automatic vec_t mk(input logic [N-1:0] se, input logic [W-1:0] d,
                               input logic [N-1:0] act, input logic [N*AB-1:0] frm,
                               input logic [N-1:0] rdy, input logic [N-1:0] een,
                               input int rx, input logic [W-1:0] ew,
                               input logic [N*CB-1:0] eocc, input logic [N-1:0] esr,
                               input logic [N-1:0] eovf);
      vec_t v;
      v.send_en = se;   v.data = d;     v.act = act;  v.from = frm;
      v.rdy = rdy;      v.exp_en = een; v.rx = rx;    v.exp_word = ew;
      v.exp_occ = eocc; v.exp_srdy = esr; v.exp_ovf = eovf;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h want %0h", nm, row, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      clr = 1'b0; send_en = '0; send_word = '0;
      recv_act = '0; recv_from = '0; recv_rdy = '0;
   endtask

   task automatic apply_row(input int r);
      vec_t v;
      v = tbl[r];
      @(negedge clk);
      send_en   = v.send_en;
      send_word = {N{v.data}};
      recv_act  = v.act;
      recv_from = v.from;
      recv_rdy  = v.rdy;
      #1;
      chk("recv_en", r, W'(recv_en), W'(v.exp_en));
      chk("recv_word", r, recv_word[v.rx*W +: W], v.exp_word);
      chk("occ", r, W'(occ), W'(v.exp_occ));
      chk("send_rdy", r, W'(send_rdy), W'(v.exp_srdy));
      chk("err_ovf", r, W'(err_ovf), W'(v.exp_ovf));
   endtask

   // ---------------- stimulus + scoreboard ----------------
   initial begin
      logic [N*AB-1:0] mfrom;
      logic [W-1:0]    md;
      logic [W-1:0]    exp_w;
      int              sent, got, cyc;

      rst_n = 1'b0;
      drive_idle();
      #12;
      chk("reset_srdy", 0, W'(send_rdy), W'({N{1'b1}}));
      chk("reset_en", 0, W'(recv_en), '0);
      chk("reset_occ", 0, W'(occ), '0);
      chk("reset_ovf", 0, W'(err_ovf), '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_srdy", 0, W'(send_rdy), W'({N{1'b1}}));
      chk("idle_word", 0, recv_word[W-1:0], '0);

      // Unicast: sender 1 -> receiver 3.
      tbl.push_back(mk(8'h02, 128'hA5, 8'h08, fr(3, 1), 8'h00, 8'h00, 3, '0, '0, 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h08, fr(3, 1), 8'h08, 8'h08, 3, 128'hA5, oc(1, 1), 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h08, fr(3, 1), 8'h08, 8'h00, 3, '0, '0, 8'hFF, 8'h00));
      // Multicast: receivers 0,2,5 read source 4; receiver 2 stalls first.
      mfrom = fr(0, 4) | fr(2, 4) | fr(5, 4);
      md    = 128'hC0FFEE_0000_0000_1234;
      tbl.push_back(mk(8'h10, md, 8'h25, mfrom, 8'h21, 8'h00, 2, '0, '0, 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h25, mfrom, 8'h21, 8'h04, 2, md, oc(4, 1), 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h25, mfrom, 8'h21, 8'h04, 0, '0, oc(4, 1), 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h25, mfrom, 8'h25, 8'h25, 5, md, oc(4, 1), 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h25, mfrom, 8'h25, 8'h25 & 8'h00, 0, '0, '0, 8'hFF, 8'h00));
      // Overflow: five pushes with no reader, then full + push + pop, then drain.
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(8'h01, W'(k), 8'h00, '0, 8'h00, 8'h00, 1, '0, oc(0, k - 1),
                          (k == 5) ? 8'hFE : 8'hFF, 8'h00));
      tbl.push_back(mk(8'h00, '0, 8'h00, '0, 8'h00, 8'h00, 1, '0, oc(0, 4), 8'hFE, 8'h01));
      tbl.push_back(mk(8'h01, 128'h66, 8'h02, fr(1, 0), 8'h02, 8'h02, 1, W'(1), oc(0, 4), 8'hFE, 8'h01));
      tbl.push_back(mk(8'h00, '0, 8'h02, fr(1, 0), 8'h02, 8'h02, 1, W'(2), oc(0, 3), 8'hFF, 8'h01));
      tbl.push_back(mk(8'h00, '0, 8'h02, fr(1, 0), 8'h02, 8'h02, 1, W'(3), oc(0, 2), 8'hFF, 8'h01));
      tbl.push_back(mk(8'h00, '0, 8'h02, fr(1, 0), 8'h02, 8'h02, 1, W'(4), oc(0, 1), 8'hFF, 8'h01));
      tbl.push_back(mk(8'h00, '0, 8'h02, fr(1, 0), 8'h02, 8'h00, 1, '0, '0, 8'hFF, 8'h01));

      for (int r = 0; r < tbl.size(); r++) apply_row(r);

      // Wrap: ten words through sender 7 to receiver 6, reader stalls at first.
      sent = 0; got = 0; cyc = 0;
      while (got < 10 && cyc < 60) begin
         @(negedge clk);
         send_en   = (sent < 10) ? 8'h80 : 8'h00;
         send_word = '0;
         send_word[7*W +: W] = W'(sent);
         recv_act  = 8'h40;
         recv_from = fr(6, 7);
         recv_rdy  = (cyc >= 3) ? 8'h40 : 8'h00;
         #1;
         if (recv_en[6] && recv_rdy[6]) begin
            if (exp_q.size() == 0) begin
               chk("wrap_unexpected", cyc, recv_word[6*W +: W], '1);
            end else begin
               exp_w = exp_q.pop_front();
               chk("wrap_word", cyc, recv_word[6*W +: W], exp_w);
            end
            got++;
         end
         if (send_en[7] && send_rdy[7]) begin
            exp_q.push_back(W'(sent));
            sent++;
         end
         cyc++;
      end
      chk("wrap_count", cyc, W'(got), W'(10));

      // clr with sender 2 at occ=3 and sender 0 overflowed.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive_idle();
         send_en   = (k < 3) ? 8'h05 : 8'h01;
         send_word = {N{W'(k + 16)}};
      end
      @(negedge clk);
      drive_idle();
      #1;
      chk("pre_clr_occ", 100, W'(occ), W'(oc(0, 4) | oc(2, 3)));
      chk("pre_clr_ovf", 100, W'(err_ovf), W'(8'h01));
      @(negedge clk);
      clr = 1'b1; send_en = 8'h04;
      recv_act = 8'h08; recv_from = fr(3, 2); recv_rdy = 8'h08;
      #1;
      chk("clr_en", 101, W'(recv_en), '0);
      @(negedge clk);
      clr = 1'b0; send_en = '0;
      #1;
      chk("clr_occ", 102, W'(occ), '0);
      chk("clr_ovf", 102, W'(err_ovf), '0);
      chk("clr_en_after", 102, W'(recv_en), '0);
      chk("clr_srdy", 102, W'(send_rdy), W'({N{1'b1}}));

      // Async reset mid-cycle with sender 2 at occ=3.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive_idle();
         send_en   = (k < 3) ? 8'h05 : 8'h01;
         send_word = {N{W'(k + 32)}};
      end
      @(negedge clk);
      drive_idle();
      recv_act = 8'h08; recv_from = fr(3, 2); recv_rdy = 8'h00;
      #1;
      chk("pre_rst_occ", 200, W'(occ), W'(oc(0, 4) | oc(2, 3)));
      chk("pre_rst_en", 200, W'(recv_en), W'(8'h08));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_occ", 201, W'(occ), '0);
      chk("rst_ovf", 201, W'(err_ovf), '0);
      chk("rst_en", 201, W'(recv_en), '0);
      chk("rst_srdy", 201, W'(send_rdy), W'({N{1'b1}}));
      @(negedge clk);
      rst_n = 1'b1;
      recv_rdy = 8'h08;
      @(negedge clk);
      #1;
      chk("post_rst_en", 202, W'(recv_en), '0);
      chk("post_rst_word", 202, recv_word[3*W +: W], '0);

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
